frame_checker: RTL and testbench

Sits directly downstream of the RS232 frame interface and consumes its received-frame output (fout/fout_valid).
- Recomputes CRC-32 over type, header and payload bytes.
- Validates frame type and sequence number against the current session.
- Returns the one-byte confirmation code to the interface (confirm/conf_code).
- Forwards the 64-byte payload of accepted frames to the crypto core.

---
 rtl/frame_checker_if.sv | 25 ++
 rtl/frame_checker.sv | 248 ++++++++++++++++++++++++
 tb/tb_frame_checker.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_checker_if.sv
// Frame-level handshake between the RS232 frame interface, the frame checker
// and the crypto core payload sink.
interface frame_checker_if #(
    parameter int FRAME_W = 600,
    parameter int DOUT_W  = 512
);
    logic [FRAME_W-1:0] fin;
    logic               fin_valid;
    logic               confirm;
    logic [7:0]         conf_code;
    logic [DOUT_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_first;
    logic               dout_last;

    modport master (
        output fin, fin_valid,
        input  confirm, conf_code, dout, dout_valid, dout_first, dout_last
    );

    modport slave (
        input  fin, fin_valid,
        output confirm, conf_code, dout, dout_valid, dout_first, dout_last
    );
endinterface

// File: rtl/frame_checker.sv
// Received-frame checker: CRC-32 recompute, type/session validation, confirm code
// and payload forwarding. Optional macro SEQ_CHECK_EN enables sequence/session rules.
//
// state  | meaning
// IDLE   | waiting for fin_valid, frame latched on strobe
// CRC    | one byte per cycle over type, header and payload
// CHECK  | compare CRC, apply type and session rules, pick code
// RESP   | one-cycle confirm pulse, payload forwarded on OKAY
module frame_checker #(
    parameter int DATA_SIZE     = 64,
    parameter int PREAMBLE_SIZE = 7,
    parameter int CRC_SIZE      = 4,
    parameter int FRAME_SIZE    = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8 - 1
) (
    input  logic            clk,
    input  logic            rst,
    frame_checker_if.slave  fif,
    output logic            session_active,
    output logic            busy,
    output logic [15:0]     crc_err_cnt
);

    localparam logic [7:0]  CODE_OKAY  = 8'h05;
    localparam logic [7:0]  CODE_ERROR = 8'h04;
    localparam logic [7:0]  CODE_FATAL = 8'h08;
    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;

    localparam int          CRC_BYTES  = PREAMBLE_SIZE + DATA_SIZE;
    localparam logic [6:0]  LAST_BYTE  = 7'(CRC_BYTES - 1);
    localparam int          CRC_LSB    = CRC_BYTES * 8;

    localparam logic [7:0]  T_FIRST  = 8'h00;
    localparam logic [7:0]  T_LAST   = 8'h01;
    localparam logic [7:0]  T_NORMAL = 8'h02;
    localparam logic [7:0]  T_SINGLE = 8'h03;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CRC,
        S_CHECK,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [FRAME_SIZE:0] frame_reg;
    logic [6:0]          byte_idx;
    logic [31:0]         crc_reg;
    logic [7:0]          code_reg;
    logic                accept_reg;

    logic                load, step, decide, respond;
    logic [7:0]          cur_byte;
    logic [31:0]         crc_upd;
    logic [31:0]         rx_crc;
    logic [7:0]          rx_type;
    logic                crc_ok;

    logic [7:0]          code_d;
    logic                accept_d;
    logic                sess_d;
    logic [15:0]         cnt_d;

`ifdef SEQ_CHECK_EN
    logic [31:0]         expected_seq;
    logic [31:0]         seq_d;
    logic [31:0]         rx_seq;
`endif

    // Reflected CRC-32, one full byte folded in per call
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign cur_byte = frame_reg[{byte_idx, 3'b000} +: 8];
    assign crc_upd  = crc_byte(crc_reg, cur_byte);
    assign rx_type  = frame_reg[7:0];
    assign rx_crc   = {frame_reg[CRC_LSB +: 8],      frame_reg[CRC_LSB + 8 +: 8],
                       frame_reg[CRC_LSB + 16 +: 8], frame_reg[CRC_LSB + 24 +: 8]};
    assign crc_ok   = (crc_reg == rx_crc);

`ifdef SEQ_CHECK_EN
    assign rx_seq   = {frame_reg[31:24], frame_reg[39:32], frame_reg[47:40], frame_reg[55:48]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        load      = 1'b0;
        step      = 1'b0;
        decide    = 1'b0;
        respond   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (fif.fin_valid) begin
                    load      = 1'b1;
                    state_nxt = S_CRC;
                end
            end
            S_CRC: begin
                step = 1'b1;
                if (byte_idx == LAST_BYTE) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                decide    = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                respond   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CRC errors outrank unknown types, which outrank session rules
    always_comb begin
        code_d   = CODE_ERROR;
        accept_d = 1'b0;
        sess_d   = session_active;
        cnt_d    = crc_err_cnt;
`ifdef SEQ_CHECK_EN
        seq_d    = expected_seq;
`endif
        if (!crc_ok) begin
            code_d = CODE_ERROR;
            if (crc_err_cnt != 16'hFFFF) begin
                cnt_d = crc_err_cnt + 16'd1;
            end
        end else if (rx_type > T_SINGLE) begin
            code_d = CODE_FATAL;
            sess_d = 1'b0;
`ifdef SEQ_CHECK_EN
            seq_d  = 32'h0;
`endif
        end else begin
`ifdef SEQ_CHECK_EN
            case (rx_type)
                T_FIRST: begin
                    if (rx_seq == 32'h0) begin
                        accept_d = 1'b1;
                        sess_d   = 1'b1;
                        seq_d    = 32'h1;
                    end
                end
                T_NORMAL: begin
                    if (session_active && rx_seq == expected_seq) begin
                        accept_d = 1'b1;
                        seq_d    = expected_seq + 32'h1;
                    end
                end
                T_LAST: begin
                    if (session_active && rx_seq == expected_seq) begin
                        accept_d = 1'b1;
                        sess_d   = 1'b0;
                        seq_d    = 32'h0;
                    end
                end
                default: begin
                    accept_d = !session_active;
                end
            endcase
`else
            accept_d = 1'b1;
            if (rx_type == T_FIRST) begin
                sess_d = 1'b1;
            end else if (rx_type == T_LAST) begin
                sess_d = 1'b0;
            end
`endif
            code_d = accept_d ? CODE_OKAY : CODE_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg       <= '0;
            byte_idx        <= 7'd0;
            crc_reg         <= 32'hFFFF_FFFF;
            code_reg        <= 8'h00;
            accept_reg      <= 1'b0;
            session_active  <= 1'b0;
            crc_err_cnt     <= 16'h0;
            fif.confirm     <= 1'b0;
            fif.conf_code   <= 8'h00;
            fif.dout        <= '0;
            fif.dout_valid  <= 1'b0;
            fif.dout_first  <= 1'b0;
            fif.dout_last   <= 1'b0;
`ifdef SEQ_CHECK_EN
            expected_seq    <= 32'h0;
`endif
        end else begin
            fif.confirm    <= 1'b0;
            fif.dout_valid <= 1'b0;

            if (load) begin
                frame_reg <= fif.fin;
                byte_idx  <= 7'd0;
                crc_reg   <= 32'hFFFF_FFFF;
            end

            if (step) begin
                byte_idx <= byte_idx + 7'd1;
                crc_reg  <= (byte_idx == LAST_BYTE) ? ~crc_upd : crc_upd;
            end

            if (decide) begin
                code_reg       <= code_d;
                accept_reg     <= accept_d;
                session_active <= sess_d;
                crc_err_cnt    <= cnt_d;
`ifdef SEQ_CHECK_EN
                expected_seq   <= seq_d;
`endif
            end

            // frame_reg cannot be reloaded before IDLE, so type is still valid here
            if (respond) begin
                fif.confirm   <= 1'b1;
                fif.conf_code <= code_reg;
                if (accept_reg) begin
                    fif.dout_valid <= 1'b1;
                    fif.dout       <= frame_reg[PREAMBLE_SIZE*8 +: DATA_SIZE*8];
                    fif.dout_first <= (rx_type == T_FIRST) || (rx_type == T_SINGLE);
                    fif.dout_last  <= (rx_type == T_LAST)  || (rx_type == T_SINGLE);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_checker.sv
// Directed, table-driven bench for frame_checker with a bitwise CRC-32 reference.
module tb_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        session_active;
    logic        busy;
    logic [15:0] crc_err_cnt;

    frame_checker_if fif ();

    frame_checker dut (
        .clk            (clk),
        .rst            (rst),
        .fif            (fif),
        .session_active (session_active),
        .busy           (busy),
        .crc_err_cnt    (crc_err_cnt)
    );

    always #5 clk = ~clk;

`ifdef SEQ_CHECK_EN
    localparam logic [7:0] SEQ_ERR = 8'h04;
`else
    localparam logic [7:0] SEQ_ERR = 8'h05;
`endif

    typedef struct {
        logic [7:0]  ftype;
        logic [31:0] seq;
        logic [7:0]  base;
        bit          corrupt;
        logic [7:0]  code;
        bit          first;
        bit          last;
        bit          sess;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [511:0] exp_dout = '0;
    logic [15:0]  exp_err  = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bit-serial reference, LSB of each byte first
    function automatic logic [31:0] crc_model(input logic [599:0] f);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 71 * 8; i++) begin
            fb = c[0] ^ f[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return ~c;
    endfunction

    function automatic logic [599:0] make_frame(input logic [7:0] ftype, input logic [31:0] seq,
                                                input logic [7:0] base);
        logic [599:0] f;
        logic [31:0]  c;
        f = '0;
        f[7:0]   = ftype;
        f[31:24] = seq[31:24];
        f[39:32] = seq[23:16];
        f[47:40] = seq[15:8];
        f[55:48] = seq[7:0];
        for (int j = 0; j < 64; j++) f[(7 + j) * 8 +: 8] = base + 8'(j);
        c = crc_model(f);
        f[575:568] = c[31:24];
        f[583:576] = c[23:16];
        f[591:584] = c[15:8];
        f[599:592] = c[7:0];
        return f;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        logic [599:0] f;
        logic [7:0]   code_seen;
        int           lat;
        bit           seen;
        f = make_frame(v.ftype, v.seq, v.base);
        if (v.corrupt) f[575:568] = f[575:568] ^ 8'h01;
        @(negedge clk);
        fif.fin       = f;
        fif.fin_valid = 1'b1;
        @(posedge clk);
        #1 fif.fin_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) chk({tag, " busy"}, 64'(busy), 64'd1);
            if (fif.confirm) seen = 1'b1;
        end
        chk({tag, " latency"}, 64'(lat), 64'd73);
        chk({tag, " conf_code"}, 64'(fif.conf_code), 64'(v.code));
        chk({tag, " dout_valid"}, 64'(fif.dout_valid), 64'(v.code == 8'h05));
        if (v.corrupt) exp_err++;
        if (v.code == 8'h05) begin
            exp_dout = f[567:56];
            chk({tag, " dout_first"}, 64'(fif.dout_first), 64'(v.first));
            chk({tag, " dout_last"}, 64'(fif.dout_last), 64'(v.last));
        end
        chk_wide({tag, " dout"}, fif.dout, exp_dout);
        chk({tag, " session_active"}, 64'(session_active), 64'(v.sess));
        chk({tag, " crc_err_cnt"}, 64'(crc_err_cnt), 64'(exp_err));
        code_seen = fif.conf_code;
        @(posedge clk);
        #1;
        chk({tag, " confirm_pulse"}, 64'(fif.confirm), 64'd0);
        chk({tag, " code_hold"}, 64'(fif.conf_code), 64'(code_seen));
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " confirm"}, 64'(fif.confirm), 64'd0);
        chk({tag, " conf_code"}, 64'(fif.conf_code), 64'd0);
        chk_wide({tag, " dout"}, fif.dout, 512'd0);
        chk({tag, " flags"}, 64'({fif.dout_valid, fif.dout_first, fif.dout_last}), 64'd0);
        chk({tag, " session_active"}, 64'(session_active), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " crc_err_cnt"}, 64'(crc_err_cnt), 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        int  cyc;
        bit  seen;

        vecs[0]  = '{8'h03, 32'd0, 8'h00, 1'b0, 8'h05,  1'b1, 1'b1, 1'b0};
        vecs[1]  = '{8'h03, 32'd0, 8'h00, 1'b1, 8'h04,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 32'd0, 8'h20, 1'b0, 8'h05,  1'b1, 1'b0, 1'b1};
        vecs[3]  = '{8'h02, 32'd1, 8'h30, 1'b0, 8'h05,  1'b0, 1'b0, 1'b1};
        vecs[4]  = '{8'h02, 32'd5, 8'h40, 1'b0, SEQ_ERR, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h02, 32'd2, 8'h50, 1'b0, 8'h05,  1'b0, 1'b0, 1'b1};
        vecs[6]  = '{8'h01, 32'd3, 8'h60, 1'b0, 8'h05,  1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 32'd0, 8'h70, 1'b0, 8'h05,  1'b1, 1'b0, 1'b1};
        vecs[8]  = '{8'h09, 32'd1, 8'h80, 1'b0, 8'h08,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h02, 32'd0, 8'h90, 1'b0, SEQ_ERR, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h03, 32'd7, 8'hA0, 1'b0, 8'h05,  1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'h00, 32'd0, 8'hB0, 1'b0, 8'h05,  1'b1, 1'b0, 1'b1};
        vecs[12] = '{8'h03, 32'd0, 8'hC0, 1'b0, SEQ_ERR, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{8'h00, 32'd3, 8'hD0, 1'b0, SEQ_ERR, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{8'h01, 32'd1, 8'hE0, 1'b0, 8'h05,  1'b0, 1'b1, 1'b0};

        rst           = 1'b1;
        fif.fin       = '0;
        fif.fin_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_all_zero("reset");

        for (int i = 0; i < 15; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // fin_valid while busy is dropped: only one confirm for two strobes
        @(negedge clk);
        fif.fin       = make_frame(8'h03, 32'd0, 8'h11);
        fif.fin_valid = 1'b1;
        @(posedge clk);
        #1 fif.fin_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 fif.fin       = make_frame(8'h03, 32'd0, 8'h22);
        fif.fin_valid = 1'b1;
        @(posedge clk);
        #1 fif.fin_valid = 1'b0;
        cyc = 0;
        for (int k = 0; k < 160; k++) begin
            @(posedge clk);
            #1;
            if (fif.confirm) cyc++;
        end
        chk("busy_drop confirm_count", 64'(cyc), 64'd1);
        chk_wide("busy_drop dout", fif.dout, make_frame(8'h03, 32'd0, 8'h11) >> 56);
        exp_dout = fif.dout;

        // reset during CRC aborts with no confirm pulse
        @(negedge clk);
        fif.fin       = make_frame(8'h03, 32'd0, 8'h00);
        fif.fin_valid = 1'b1;
        @(posedge clk);
        #1 fif.fin_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_all_zero("mid_rst");
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (fif.confirm) seen = 1'b1;
        end
        chk("mid_rst no_confirm", 64'(seen), 64'd0);
        exp_dout = '0;
        exp_err  = 16'h0;
        run_frame(vecs[0], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
